// File: rtl/exc_commit_if.sv
// exc_commit_if: WB/csr/IF signal bundle around the exception commit sequencer
interface exc_commit_if;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic [5:0]  wb_exc_vec;
  logic        wb_ertn;
  logic        int_pending;
  logic [31:0] csr_target_pc;
  logic        redirect_ready;
  logic        csr_exc_signal;
  logic        csr_ertn_signal;
  logic [5:0]  csr_exc_ecode;
  logic [8:0]  csr_exc_esubcode;
  logic [31:0] csr_exc_pc;
  logic [31:0] csr_exc_vaddr;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;
  modport slave (
    input  wb_valid, wb_pc, wb_vaddr, wb_exc_vec, wb_ertn, int_pending, csr_target_pc, redirect_ready,
    output csr_exc_signal, csr_ertn_signal, csr_exc_ecode, csr_exc_esubcode, csr_exc_pc, csr_exc_vaddr,
           flush, redirect_valid, redirect_pc, busy
  );
  modport master (
    output wb_valid, wb_pc, wb_vaddr, wb_exc_vec, wb_ertn, int_pending, csr_target_pc, redirect_ready,
    input  csr_exc_signal, csr_ertn_signal, csr_exc_ecode, csr_exc_esubcode, csr_exc_pc, csr_exc_vaddr,
           flush, redirect_valid, redirect_pc, busy
  );
endinterface

// File: rtl/exc_commit_ctrl.sv
// exc_commit_ctrl: exception/ERTN commit sequencer (csr event, flush, IF redirect); EXC_INT_ACCEPT_EN enables interrupts
module exc_commit_ctrl (
  input logic         clk,
  input logic         resetn,
  exc_commit_if.slave ifc
);
  typedef enum logic [1:0] {IDLE, COMMIT, REDIRECT} state_t;
  state_t      state_q, state_d;
  logic        exc_q, exc_d, ertn_q, ertn_d, flush_q, flush_d, rv_q, rv_d, busy_q, busy_d;
  logic [5:0]  ecode_q, ecode_d;
  logic [8:0]  sub_q, sub_d;
  logic [31:0] pc_q, pc_d, vaddr_q, vaddr_d, rpc_q, rpc_d;
  logic        int_req, any_exc, take;
  logic [5:0]  ev;
  logic [5:0]  ev_ecode;
  logic [8:0]  ev_sub;
  logic [31:0] ev_vaddr;
`ifdef EXC_INT_ACCEPT_EN
  assign int_req = ifc.int_pending;
`else
  logic unused_int;
  assign int_req    = 1'b0;
  assign unused_int = ifc.int_pending;
`endif
  // prioritize INT > ADEF > INE > SYS > BRK > ALE > ADEM; no source left means ERTN with zero fields
  always_comb begin
    ev       = ifc.wb_exc_vec;
    any_exc  = int_req | (|ev);
    take     = ifc.wb_valid & (any_exc | ifc.wb_ertn);
    ev_ecode = int_req ? 6'h00 : ev[0] ? 6'h08 : ev[1] ? 6'h0D : ev[2] ? 6'h0B :
               ev[3] ? 6'h0C : ev[4] ? 6'h09 : ev[5] ? 6'h08 : 6'h00;
    ev_sub   = (!int_req && ev == 6'b100000) ? 9'd1 : 9'd0;
    ev_vaddr = int_req ? 32'h0 : ev[0] ? ifc.wb_pc : (|ev[3:1]) ? 32'h0 :
               (|ev[5:4]) ? ifc.wb_vaddr : 32'h0;
  end
  // sequence IDLE -> COMMIT -> REDIRECT -> IDLE; signal bits pulse only in COMMIT, fields hold until next take
  always_comb begin
    state_d = state_q;
    exc_d   = 1'b0;
    ertn_d  = 1'b0;
    ecode_d = ecode_q;
    sub_d   = sub_q;
    pc_d    = pc_q;
    vaddr_d = vaddr_q;
    flush_d = flush_q;
    rv_d    = rv_q;
    rpc_d   = rpc_q;
    unique case (state_q)
      IDLE: if (take) begin
        state_d = COMMIT;
        exc_d   = any_exc;
        ertn_d  = ~any_exc;
        ecode_d = ev_ecode;
        sub_d   = ev_sub;
        pc_d    = ifc.wb_pc;
        vaddr_d = ev_vaddr;
        flush_d = 1'b1;
      end
      COMMIT: begin
        state_d = REDIRECT;
        rv_d    = 1'b1;
        rpc_d   = ifc.csr_target_pc;
        flush_d = 1'b1;
      end
      REDIRECT: if (ifc.redirect_ready) begin
        state_d = IDLE;
        rv_d    = 1'b0;
        flush_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  // state and registered outputs; reset cuts any pulse in flight
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      exc_q   <= 1'b0;
      ertn_q  <= 1'b0;
      ecode_q <= '0;
      sub_q   <= '0;
      pc_q    <= '0;
      vaddr_q <= '0;
      flush_q <= 1'b0;
      rv_q    <= 1'b0;
      rpc_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      exc_q   <= exc_d;
      ertn_q  <= ertn_d;
      ecode_q <= ecode_d;
      sub_q   <= sub_d;
      pc_q    <= pc_d;
      vaddr_q <= vaddr_d;
      flush_q <= flush_d;
      rv_q    <= rv_d;
      rpc_q   <= rpc_d;
      busy_q  <= busy_d;
    end
  end
  assign ifc.csr_exc_signal   = exc_q;
  assign ifc.csr_ertn_signal  = ertn_q;
  assign ifc.csr_exc_ecode    = ecode_q;
  assign ifc.csr_exc_esubcode = sub_q;
  assign ifc.csr_exc_pc       = pc_q;
  assign ifc.csr_exc_vaddr    = vaddr_q;
  assign ifc.flush            = flush_q;
  assign ifc.redirect_valid   = rv_q;
  assign ifc.redirect_pc      = rpc_q;
  assign ifc.busy             = busy_q;
endmodule

// File: doc/exc_commit_ctrl.md
# exc_commit_ctrl

Exception/ERTN commit sequencer between the WB stage and the `csr` block. It prioritizes the exception sources of the committing instruction and the pending interrupt, then issues a single-cycle `EXC_signal`/`ERTN_signal` event with ecode, subcode, PC and vaddr to `csr`. It then holds a pipeline-wide flush and performs a valid/ready redirect handshake with IF using the target PC returned by `csr`.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; one clock; reset is asynchronous and active-low
- wb_valid  in  1  WB instruction is committing this cycle
- wb_pc  in  32  PC of the WB instruction
- wb_vaddr  in  32  memory access address of the WB instruction
- wb_exc_vec  in  6  exception flags: [0] ADEF, [1] INE, [2] SYS, [3] BRK, [4] ALE, [5] ADEM
- wb_ertn  in  1  WB instruction is ERTN
- int_pending  in  1  `INT_signal` from csr
- csr_target_pc  in  32  `CSR_2_IF_pc` from csr
- redirect_ready  in  1  IF accepts the redirect
- csr_exc_signal  out  1  to csr `EXC_signal`
- csr_ertn_signal  out  1  to csr `ERTN_signal`
- csr_exc_ecode  out  6  to csr `EXC_ecode`
- csr_exc_esubcode  out  9  to csr `EXC_esubcode`
- csr_exc_pc  out  32  to csr `EXC_pc`
- csr_exc_vaddr  out  32  to csr `EXC_vaddr`
- flush  out  1  kill all in-flight instructions (IF..WB)
- redirect_valid  out  1  redirect request to IF
- redirect_pc  out  32  new fetch PC
- busy  out  1  state != IDLE

## Operation
- States: IDLE, COMMIT, REDIRECT. Reset → IDLE. All outputs are registered and reset to 0.
- Trigger in IDLE: `take = wb_valid & (int_pending | |wb_exc_vec | wb_ertn)`. Triggers in COMMIT or REDIRECT are ignored, because flush covers those instructions.
- Priority (highest first), ecode/subcode/vaddr:
  - INT: 0x00/0/0
  - ADEF: 0x08/0/wb_pc
  - INE: 0x0D/0/0
  - SYS: 0x0B/0/0
  - BRK: 0x0C/0/0
  - ALE: 0x09/0/wb_vaddr
  - ADEM: 0x08/1/wb_vaddr
  - ERTN: ertn event, ecode/subcode/vaddr 0
- Any exception or INT suppresses `wb_ertn` in the same cycle. Exactly one of `csr_exc_signal`/`csr_ertn_signal` is ever high.
- `csr_exc_pc` = wb_pc for all events.
- IDLE & take → COMMIT:
  - event outputs registered; `csr_*_signal` high for exactly this one cycle
  - flush = 1
  - `csr_target_pc` sampled at the end of COMMIT into `redirect_pc`
- COMMIT → REDIRECT unconditionally:
  - `redirect_valid` = 1, flush = 1
  - `redirect_pc` held stable until handshake
- REDIRECT & redirect_ready → IDLE: `redirect_valid` and flush are deasserted in IDLE.
- Event fields (ecode, subcode, pc, vaddr) hold their values after COMMIT until the next take. The signal bits are the only pulsed outputs.

## Timing
- Cycle T: take seen.
- T+1: COMMIT (csr event, flush).
- T+2 onward: REDIRECT.
- Handshake completes on the first edge with `redirect_valid & redirect_ready`; minimum event-to-IDLE is 3 cycles.
- A back-to-back take is possible on the first IDLE cycle after the handshake.
- `redirect_ready` high during COMMIT has no effect.
- `resetn` low at any time: immediate return to IDLE, all outputs 0, including a mid-COMMIT pulse, which is cut.
- wb_valid = 0: no event, even if `int_pending` = 1. Interrupts attach only to a committing instruction.

## Configuration
- `EXC_INT_ACCEPT_EN` defined: INT participates at top priority as above.
- Not defined: `int_pending` is ignored entirely, ecode 0x00 is never produced, and take excludes the interrupt term.

## Test plan
- wb_valid=1, wb_exc_vec=6'b000100, wb_pc=0x1c000040, csr_target_pc=0x1c008000, redirect_ready=1 → T+1: exc_signal=1, ecode=0x0B, pc=0x1c000040; T+2: redirect_valid=1, redirect_pc=0x1c008000; T+3: IDLE, flush=0.
- wb_exc_vec=6'b110001, wb_vaddr=0x13 → ADEF wins: ecode=0x08, subcode=0, vaddr=wb_pc.
- wb_ertn=1 alone, csr_target_pc=0x1c000100, redirect_ready held 0 for 4 cycles → ertn_signal pulse 1 cycle, redirect_valid and redirect_pc=0x1c000100 stable 4 cycles, then IDLE one cycle after ready.
- int_pending=1 with wb_exc_vec=6'b010000, wb_ertn=1 → with `EXC_INT_ACCEPT_EN`: ecode=0x00, no ertn; without: ecode=0x09, vaddr=wb_vaddr.
- A second take during REDIRECT → ignored, no second csr pulse; resetn low mid-REDIRECT → all outputs 0 immediately, state IDLE.
